// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg: opcodes, FSM state encoding and flag bit indices shared by the
// accumulator core and its ALU.
// Build option: ACC_CPU_MUL_EN makes opcode E a multiply that reads memory;
// without it opcode E behaves as a NOP.
package acc_cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_STA = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_NOT = 4'h7,
        OP_JMP = 4'h8,
        OP_JZ  = 4'h9,
        OP_JN  = 4'hA,
        OP_JC  = 4'hB,
        OP_LDI = 4'hC,
        OP_OUT = 4'hD,
        OP_MUL = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_READ   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam int FLAG_Z  = 0;
    localparam int FLAG_N  = 1;
    localparam int FLAG_C  = 2;
    localparam int N_FLAGS = 3;

    // Instructions whose operand is a memory word fetched in READ.
    function automatic logic op_reads_mem(input opcode_t op);
        logic r;
        case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: r = 1'b1;
`ifdef ACC_CPU_MUL_EN
            OP_MUL:                                r = 1'b1;
`endif
            default:                               r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// acc_cpu_alu: combinational accumulator ALU. Produces the next ACC value and
// the Z/N/C flags; C passes through unchanged for instructions that do not
// define a carry.
// Build option: ACC_CPU_MUL_EN adds the unsigned multiplier for opcode E.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 16
)(
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    input  logic              c_in,
    output logic [DATA_W-1:0] result,
    output logic              z_out,
    output logic              n_out,
    output logic              c_out
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, acc} + {1'b0, operand};
    // A borrow shows up as the extra top bit going high.
    assign diff = {1'b0, acc} - {1'b0, operand};

`ifdef ACC_CPU_MUL_EN
    logic [2*DATA_W-1:0] prod;
    assign prod = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, operand};
`endif

    // Result and carry selection by opcode.
    always_comb begin
        result = acc;
        c_out  = c_in;
        case (op)
            OP_LDA, OP_LDI: result = operand;
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                c_out  = sum[DATA_W];
            end
            OP_SUB: begin
                result = diff[DATA_W-1:0];
                c_out  = diff[DATA_W];
            end
            OP_AND: result = acc & operand;
            OP_OR:  result = acc | operand;
            OP_NOT: result = ~acc;
`ifdef ACC_CPU_MUL_EN
            OP_MUL: begin
                result = prod[DATA_W-1:0];
                c_out  = |prod[2*DATA_W-1:DATA_W];
            end
`endif
            default: ;
        endcase
    end

    assign z_out = (result == '0);
    assign n_out = result[DATA_W-1];

endmodule

// File: rtl/acc_cpu.sv
// acc_cpu: multi-cycle accumulator core with a single request/ack memory port
// shared by instruction fetch and data access.
// Build option: ACC_CPU_MUL_EN enables opcode E (MUL) through the ALU.
//
// state  | meaning
// BOOT   | after reset, no request; moves to FETCH
// FETCH  | read M[PC]; on ack latch IR and increment PC
// DECODE | execute register-only ops and branches, or pick READ/WRITE/HALT
// READ   | read M[A]; on ack write ALU result to ACC and flags
// WRITE  | write ACC to M[A]; completes on ack
// HALT   | terminal until reset
module acc_cpu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
)(
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    state_t              state;
    state_t              state_nxt;
    opcode_t             ir_op;
    logic [ADDR_W-1:0]   ir_a;
    logic [DATA_W-1:0]   acc;
    logic [N_FLAGS-1:0]  flags;

    logic [DATA_W-1:0]   ldi_operand;
    logic [DATA_W-1:0]   alu_operand;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_z;
    logic                alu_n;
    logic                alu_c;

    logic                ir_load;
    logic                acc_we;
    logic                branch_taken;
    logic                out_load;

    assign ldi_operand = {{(DATA_W-ADDR_W){1'b0}}, ir_a};

    acc_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op      (ir_op),
        .acc     (acc),
        .operand (alu_operand),
        .c_in    (flags[FLAG_C]),
        .result  (alu_result),
        .z_out   (alu_z),
        .n_out   (alu_n),
        .c_out   (alu_c)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, memory port decode and datapath strobes.
    always_comb begin
        state_nxt    = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = pc;
        alu_operand  = mem_rdata;
        ir_load      = 1'b0;
        acc_we       = 1'b0;
        branch_taken = 1'b0;
        out_load     = 1'b0;

        case (state)
            ST_BOOT: begin
                state_nxt = ST_FETCH;
            end

            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load   = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end

            ST_DECODE: begin
                alu_operand = ldi_operand;
                state_nxt   = ST_FETCH;
                if (op_reads_mem(ir_op)) begin
                    state_nxt = ST_READ;
                end else begin
                    case (ir_op)
                        OP_STA:         state_nxt    = ST_WRITE;
                        OP_HLT:         state_nxt    = ST_HALT;
                        OP_NOT, OP_LDI: acc_we       = 1'b1;
                        OP_JMP:         branch_taken = 1'b1;
                        OP_JZ:          branch_taken = flags[FLAG_Z];
                        OP_JN:          branch_taken = flags[FLAG_N];
                        OP_JC:          branch_taken = flags[FLAG_C];
                        OP_OUT:         out_load     = 1'b1;
                        default: ;
                    endcase
                end
            end

            ST_READ: begin
                mem_req  = 1'b1;
                mem_addr = ir_a;
                if (mem_ack) begin
                    acc_we    = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end

            ST_WRITE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = ir_a;
                if (mem_ack) begin
                    state_nxt = ST_FETCH;
                end
            end

            ST_HALT: begin
                state_nxt = ST_HALT;
            end

            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    // PC, IR, ACC, flags and output port registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= ADDR_W'(RESET_PC);
            ir_op     <= OP_NOP;
            ir_a      <= '0;
            acc       <= '0;
            flags     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_load;
            if (ir_load) begin
                ir_op <= opcode_t'(mem_rdata[DATA_W-1 -: 4]);
                ir_a  <= mem_rdata[ADDR_W-1:0];
                pc    <= pc + ADDR_W'(1);
            end
            if (branch_taken) begin
                pc <= ir_a;
            end
            if (acc_we) begin
                acc           <= alu_result;
                flags[FLAG_Z] <= alu_z;
                flags[FLAG_N] <= alu_n;
                flags[FLAG_C] <= alu_c;
            end
            if (out_load) begin
                out_data <= acc;
            end
        end
    end

    assign mem_wdata = acc;
    assign halted    = (state == ST_HALT);

endmodule
